// File: rtl/lut_div_pkg.sv
// Shared widths, constants and reciprocal helper for the LUT-based 8-bit divider.
package lut_div_pkg;

  localparam int unsigned DIVIDEND_W = 8;
  localparam int unsigned DIVISOR_W  = 8;
  localparam int unsigned RECIP_W    = 17;
  localparam int unsigned QUOT_W     = 14;
  localparam int unsigned FRAC_BITS  = 6;
  localparam int unsigned SHIFT      = 10;
  localparam int unsigned PROD_W     = DIVIDEND_W + RECIP_W;
  localparam int unsigned ROM_DEPTH  = 1 << DIVISOR_W;

  localparam logic [QUOT_W-1:0] QUOT_SAT = 14'h3FFF;

  // floor(65536/d); d = 0 maps to 0 and is overridden downstream.
  function automatic logic [RECIP_W-1:0] recip(input logic [DIVISOR_W-1:0] d);
    logic [31:0] q;
    if (d == '0) begin
      return '0;
    end
    q = 32'd65536 / {{(32 - DIVISOR_W){1'b0}}, d};
    return q[RECIP_W-1:0];
  endfunction

endpackage

// File: rtl/lut_div_recip_rom.sv
// 256 x 17 combinational reciprocal ROM, contents fixed at elaboration.
module lut_div_recip_rom
  import lut_div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] addr_i,
  output logic [RECIP_W-1:0]   recip_o
);

  logic [RECIP_W-1:0] rom [ROM_DEPTH];

  for (genvar i = 0; i < int'(ROM_DEPTH); i++) begin : g_rom
    assign rom[i] = recip(DIVISOR_W'(i));
  end

  assign recip_o = rom[addr_i];

endmodule

// File: rtl/lut_div_8bits.sv
// Two-stage pipelined divider: reciprocal lookup, then multiply-shift into a Q8.6 quotient.
module lut_div_8bits
  import lut_div_pkg::*;
(
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_START,
  input  logic [DIVIDEND_W-1:0] i_DIVIDEND,
  input  logic [DIVISOR_W-1:0]  i_DIVISOR,
  output logic [QUOT_W-1:0]     o_QUOTIENT
);

  logic [RECIP_W-1:0] rom_recip;

  lut_div_recip_rom u_recip_rom (
    .addr_i  (i_DIVISOR),
    .recip_o (rom_recip)
  );

  logic                  valid_q;
  logic [DIVIDEND_W-1:0] x_q;
  logic [RECIP_W-1:0]    recip_q;
  logic                  div_zero_q;

  // Stage 1: capture operand and reciprocal; the valid token tracks i_START every cycle.
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      valid_q    <= 1'b0;
      x_q        <= '0;
      recip_q    <= '0;
      div_zero_q <= 1'b0;
    end else begin
      valid_q <= i_START;
      if (i_START) begin
        x_q        <= i_DIVIDEND;
        recip_q    <= rom_recip;
        div_zero_q <= (i_DIVISOR == '0);
      end
    end
  end

  logic [PROD_W-1:0] prod;
  logic [QUOT_W-1:0] quot_d, quot_q;

  assign prod = PROD_W'(x_q) * PROD_W'(recip_q);

  // Product never exceeds 255 * 65536, so the truncation below cannot overflow.
  always_comb begin
    quot_d = quot_q;
    if (valid_q) begin
      quot_d = div_zero_q ? QUOT_SAT : QUOT_W'(prod >> SHIFT);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      quot_q <= '0;
    end else begin
      quot_q <= quot_d;
    end
  end

  assign o_QUOTIENT = quot_q;

endmodule

// File: tb/tb_lut_div_8bits.sv
// Self-checking bench: vector table, sweeps and start/reset sequences against a scoreboard.
module tb_lut_div_8bits;
  import lut_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  dividend = '0;
  logic [7:0]  divisor = '0;
  logic [13:0] quot;

  lut_div_8bits dut (
    .i_CLK      (clk),
    .i_RSTn     (rst_n),
    .i_START    (start),
    .i_DIVIDEND (dividend),
    .i_DIVISOR  (divisor),
    .o_QUOTIENT (quot)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [13:0] q;
  } sb_entry_t;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  d;
    logic [13:0] q;
  } vec_t;

  sb_entry_t   sb[$];
  logic [13:0] exp_hold = '0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [13:0] golden(input logic [7:0] x, input logic [7:0] d);
    logic [24:0] p;
    if (d == 8'd0) return 14'h3FFF;
    p = {17'd0, x} * {8'd0, recip(d)};
    p = p >> 10;
    return p[13:0];
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, model the edge, then sample 1 time unit after it.
  task automatic tick(input logic rstn, input logic st, input logic [7:0] x,
                      input logic [7:0] d, input logic [13:0] expq, input string name);
    rst_n    = rstn;
    start    = st;
    dividend = x;
    divisor  = d;
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      sb.delete();
      exp_hold = '0;
    end else if (st) begin
      sb.push_back('{due: cyc + 1, q: expq});
    end
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_hold = sb[0].q;
      void'(sb.pop_front());
      check(name, quot, exp_hold);
    end else begin
      check({name, "_hold"}, quot, exp_hold);
    end
  endtask

  vec_t vecs[12];

  initial begin
    logic [7:0] rx, rd;
    vecs = '{
      '{x: 8'd50,  d: 8'd0,   q: 14'd16383},
      '{x: 8'd50,  d: 8'd1,   q: 14'd3200},
      '{x: 8'd50,  d: 8'd7,   q: 14'd457},
      '{x: 8'd50,  d: 8'd50,  q: 14'd63},
      '{x: 8'd50,  d: 8'd255, q: 14'd12},
      '{x: 8'd255, d: 8'd0,   q: 14'd16383},
      '{x: 8'd255, d: 8'd1,   q: 14'd16320},
      '{x: 8'd255, d: 8'd3,   q: 14'd5439},
      '{x: 8'd255, d: 8'd255, q: 14'd63},
      '{x: 8'd0,   d: 8'd0,   q: 14'd16383},
      '{x: 8'd0,   d: 8'd1,   q: 14'd0},
      '{x: 8'd0,   d: 8'd255, q: 14'd0}
    };

    // Reset held for two edges with random live operands.
    for (int i = 0; i < 2; i++) begin
      rx = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      tick(1'b0, 1'b1, rx, rd, 14'd0, "reset");
    end
    tick(1'b1, 1'b0, 8'd9, 8'd3, 14'd0, "post_reset");

    // Hand-computed vectors back-to-back.
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, vecs[i].x, vecs[i].d, vecs[i].q, "vec");
    end

    // Full divisor sweeps.
    for (int d = 0; d < 256; d++) tick(1'b1, 1'b1, 8'd50, 8'(d), golden(8'd50, 8'(d)), "sweep50");
    for (int d = 0; d < 256; d++) tick(1'b1, 1'b1, 8'd0, 8'(d), golden(8'd0, 8'(d)), "sweep0");

    // Start toggling: output only moves two cycles after each high sample.
    tick(1'b1, 1'b0, 8'd1, 8'd1, 14'd0, "idle");
    tick(1'b1, 1'b0, 8'd1, 8'd1, 14'd0, "idle");
    tick(1'b1, 1'b1, 8'd100, 8'd3,  golden(8'd100, 8'd3), "tog");
    tick(1'b1, 1'b0, 8'd200, 8'd7,  14'd0, "tog");
    tick(1'b1, 1'b0, 8'd17,  8'd0,  14'd0, "tog");
    tick(1'b1, 1'b1, 8'd77,  8'd9,  golden(8'd77, 8'd9), "tog");
    tick(1'b1, 1'b0, 8'd5,   8'd0,  14'd0, "tog");
    tick(1'b1, 1'b0, 8'd5,   8'd2,  14'd0, "tog");

    // x = 255 sweep with a one-cycle reset in the middle.
    for (int d = 0; d < 256; d++) begin
      if (d == 100) tick(1'b0, 1'b1, 8'd255, 8'd1, 14'd0, "midreset");
      tick(1'b1, 1'b1, 8'd255, 8'(d), golden(8'd255, 8'(d)), "sweep255");
    end

    // Random operands with random start.
    for (int i = 0; i < 200; i++) begin
      logic st;
      rx = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      st = 1'($urandom_range(0, 1));
      tick(1'b1, st, rx, rd, golden(rx, rd), "rand");
    end

    tick(1'b1, 1'b0, 8'd0, 8'd0, 14'd0, "drain");
    tick(1'b1, 1'b0, 8'd0, 8'd0, 14'd0, "drain");
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
